mic_level_meter: RTL
====================

// Module: mic_level_meter
// PURPOSE
//   Windowed peak-level meter for the 12-bit MIC3 sample stream. Tracks the largest amplitude over
//   WINDOW_LEN accepted samples and quantises it to a NUM_LEDS-step bar with decaying peak-hold.
//   Drives the led bank directly and exports level/bar/clip to the 7-seg and OLED blocks.
//   Sits between Audio_Input (20 kHz sample strobe) and the led/seven-segment display logic.
// PARAMETERS
//   SAMPLE_W      12    sample width, unsigned offset-binary (midpoint 2**(SAMPLE_W-1))
//   NUM_LEDS      16    bar length / led output width (1..32)
//   WINDOW_LEN    2000  accepted samples per measurement window (>=2); 2000 = 0.1 s at 20 kHz
//   HOLD_WINDOWS  5     windows the peak marker is held before it starts decaying
// PORTS
//   basys_clock   in   1                    100 MHz system clock, all logic on posedge
//   reset         in   1                    synchronous, active-high
//   sample_valid  in   1                    one-cycle strobe, sample accepted on that edge
//   sample        in   SAMPLE_W             mic sample
//   mode_abs      in   1                    1: amplitude=|sample-mid|, 0: amplitude=sample (raw)
//   hold_en       in   1                    1: show peak-hold marker on led
//   freeze        in   1                    1: displayed outputs held, accumulation continues
//   led           out  NUM_LEDS             thermometer bar + hold marker
//   level         out  SAMPLE_W             peak amplitude of last completed window
//   bar           out  $clog2(NUM_LEDS+1)   bar length 0..NUM_LEDS
//   hold_idx      out  $clog2(NUM_LEDS+1)   peak-hold position 0..NUM_LEDS (0 = none)
//   clip          out  1                    last window contained sample 0 or 2**SAMPLE_W-1
//   level_valid   out  1                    one-cycle pulse when outputs update
// BEHAVIOUR
//   Reset: all outputs 0; running max 0, sample count 0, hold counter 0, latched mode = 1 (abs).
//   Accumulate: on each sample_valid edge, running_max <= max(running_max, amp); clip_acc sticky-OR.
//   amp in abs mode: sample>=mid ? sample-mid : mid-sample (range 0..mid). Raw: sample itself.
//   mode_abs latched only at window start; mid-window changes apply from the next window.
//   Window close: the edge accepting sample number WINDOW_LEN latches win_peak = max(running_max,
//   amp) and clip_win, clears running_max/clip_acc/count, relatches mode_abs. Accumulation of the next
//   window continues in the following cycles without gaps (back-to-back valids never lost).
//   Pipeline after close (not stalled by sample_valid):
//     stage QUANT (close+1): bar_q = min(NUM_LEDS, (win_peak*NUM_LEDS) >> S),
//       S = SAMPLE_W-1 (abs) or SAMPLE_W (raw); full-width product, floor, no rounding.
//     stage UPDATE (close+2): if !freeze: level,bar,clip,hold_idx,led updated, level_valid=1.
//       If freeze: level_valid stays 0, outputs and hold state unchanged, window result dropped.
//   Peak hold (per UPDATE): bar_q>=hold_idx -> hold_idx=bar_q, hold_cnt=HOLD_WINDOWS;
//     else hold_cnt!=0 -> hold_cnt-1; else hold_idx>0 -> hold_idx-1. hold_idx never below 0.
//   led[i] = (i < bar) | (hold_en & hold_idx!=0 & i==hold_idx-1). hold_en affects led only.
//   Windows closing closer than 2 cycles apart cannot occur (WINDOW_LEN>=2, one strobe per edge).
//   reset mid-window or mid-pipeline: partial window and pending result discarded, no level_valid.
// TESTING (bench overrides WINDOW_LEN=4, defaults otherwise)
//   abs, samples 2048,2048,3072,2048 -> 2 cycles after 4th: level=1024, bar=8, led=16'h00FF, hold_idx=8
//   then 6 windows of 2048 -> bar=0, led=16'h0080 for 5 windows, 6th: hold_idx=7, led=16'h0040
//   abs, window with one sample 0 -> level=2048, bar=16, led=16'hFFFF, clip=1; next clean window clip=0
//   raw, window max 4095 -> bar=15, clip=1; abs 4095 -> amp 2047, bar=15 (floor, no rounding)
//   mode_abs toggled after 2nd sample -> that window still abs; freeze=1 over close -> no pulse, outputs held
//   reset asserted between 3rd and 4th sample -> no level_valid; next 4 samples form a full new window

Source files
------------

// File: rtl/mic_level_meter_if.sv
// Sample-stream and meter-output bundle for mic_level_meter.
// The master side drives samples and controls; the slave side (meter) returns the display outputs.
interface mic_level_meter_if #(
    parameter int SAMPLE_W = 12,
    parameter int NUM_LEDS = 16
);
    localparam int BW = $clog2(NUM_LEDS + 1);

    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic                mode_abs;
    logic                hold_en;
    logic                freeze;
    logic [NUM_LEDS-1:0] led;
    logic [SAMPLE_W-1:0] level;
    logic [BW-1:0]       bar;
    logic [BW-1:0]       hold_idx;
    logic                clip;
    logic                level_valid;

    modport master (
        output sample_valid, sample, mode_abs, hold_en, freeze,
        input  led, level, bar, hold_idx, clip, level_valid
    );

    modport slave (
        input  sample_valid, sample, mode_abs, hold_en, freeze,
        output led, level, bar, hold_idx, clip, level_valid
    );
endinterface

// File: rtl/mic_level_meter.sv
// Windowed peak-level meter: per-window max amplitude, quantised to a led bar with
// decaying peak-hold marker. Window close -> QUANT -> UPDATE, two cycles of latency.
module mic_level_meter #(
    parameter int SAMPLE_W     = 12,
    parameter int NUM_LEDS     = 16,
    parameter int WINDOW_LEN   = 2000,
    parameter int HOLD_WINDOWS = 5
) (
    input  logic            basys_clock,
    input  logic            reset,
    mic_level_meter_if.slave bus
);
    localparam int BW = $clog2(NUM_LEDS + 1);
    localparam int CW = $clog2(WINDOW_LEN);
    localparam int HW = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
    localparam int PW = SAMPLE_W + BW;
    localparam logic [SAMPLE_W-1:0] MID  = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] FULL = '1;

    // accumulation state
    logic [SAMPLE_W-1:0] r_run_max;
    logic                r_clip_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_mode;
    // closed-window result
    logic                r_p1;
    logic [SAMPLE_W-1:0] r_win_peak;
    logic                r_win_clip;
    logic                r_win_mode;
    // quantised result
    logic                r_p2;
    logic [BW-1:0]       r_bar_q;
    logic [SAMPLE_W-1:0] r_q_peak;
    logic                r_q_clip;
    // display / hold state
    logic [HW-1:0]       r_hcnt;
    logic [BW-1:0]       r_hold_idx;
    logic [BW-1:0]       r_bar;
    logic [SAMPLE_W-1:0] r_level;
    logic                r_clip;
    logic [NUM_LEDS-1:0] r_led;
    logic                r_level_valid;

    logic [SAMPLE_W-1:0] w_amp;
    logic [SAMPLE_W-1:0] w_peak;
    logic                w_clip_s;
    logic                w_close;
    logic [PW-1:0]       w_prod;
    logic [PW-1:0]       w_shift;
    logic [BW-1:0]       w_bar_q;
    logic [BW-1:0]       w_hold_next;
    logic [HW-1:0]       w_hcnt_next;
    logic [NUM_LEDS-1:0] w_led_next;

    always_comb begin
        w_amp = bus.sample;
        if (r_mode) begin
            w_amp = (bus.sample >= MID) ? (bus.sample - MID) : (MID - bus.sample);
        end
        w_peak   = (w_amp > r_run_max) ? w_amp : r_run_max;
        w_clip_s = (bus.sample == '0) || (bus.sample == FULL);
        w_close  = bus.sample_valid && (r_cnt == CW'(WINDOW_LEN - 1));
    end

    // The closing sample is folded into win_peak directly, so the next window starts clean.
    always_ff @(posedge basys_clock) begin
        if (reset) begin
            r_run_max  <= '0;
            r_clip_acc <= 1'b0;
            r_cnt      <= '0;
            r_mode     <= 1'b1;
            r_p1       <= 1'b0;
            r_win_peak <= '0;
            r_win_clip <= 1'b0;
            r_win_mode <= 1'b1;
        end else begin
            r_p1 <= w_close;
            if (w_close) begin
                r_win_peak <= w_peak;
                r_win_clip <= r_clip_acc | w_clip_s;
                r_win_mode <= r_mode;
                r_run_max  <= '0;
                r_clip_acc <= 1'b0;
                r_cnt      <= '0;
                r_mode     <= bus.mode_abs;
            end else if (bus.sample_valid) begin
                r_run_max  <= w_peak;
                r_clip_acc <= r_clip_acc | w_clip_s;
                r_cnt      <= CW'(r_cnt + 1'b1);
            end
        end
    end

    always_comb begin
        w_prod  = PW'(r_win_peak) * PW'(NUM_LEDS);
        w_shift = r_win_mode ? (w_prod >> (SAMPLE_W - 1)) : (w_prod >> SAMPLE_W);
        w_bar_q = (w_shift > PW'(NUM_LEDS)) ? BW'(NUM_LEDS) : w_shift[BW-1:0];
    end

    always_ff @(posedge basys_clock) begin
        if (reset) begin
            r_p2     <= 1'b0;
            r_bar_q  <= '0;
            r_q_peak <= '0;
            r_q_clip <= 1'b0;
        end else begin
            r_p2 <= r_p1;
            if (r_p1) begin
                r_bar_q  <= w_bar_q;
                r_q_peak <= r_win_peak;
                r_q_clip <= r_win_clip;
            end
        end
    end

    always_comb begin
        w_hold_next = r_hold_idx;
        w_hcnt_next = r_hcnt;
        if (r_bar_q >= r_hold_idx) begin
            w_hold_next = r_bar_q;
            w_hcnt_next = HW'(HOLD_WINDOWS);
        end else if (r_hcnt != '0) begin
            w_hcnt_next = r_hcnt - 1'b1;
        end else if (r_hold_idx != '0) begin
            w_hold_next = r_hold_idx - 1'b1;
        end
        w_led_next = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            w_led_next[i] = (i < 32'(r_bar_q)) ||
                            (bus.hold_en && (w_hold_next != '0) && (i + 1 == 32'(w_hold_next)));
        end
    end

    // Freeze drops the window result entirely, so hold state stays put as well.
    always_ff @(posedge basys_clock) begin
        if (reset) begin
            r_hcnt        <= '0;
            r_hold_idx    <= '0;
            r_bar         <= '0;
            r_level       <= '0;
            r_clip        <= 1'b0;
            r_led         <= '0;
            r_level_valid <= 1'b0;
        end else begin
            r_level_valid <= r_p2 && !bus.freeze;
            if (r_p2 && !bus.freeze) begin
                r_hcnt     <= w_hcnt_next;
                r_hold_idx <= w_hold_next;
                r_bar      <= r_bar_q;
                r_level    <= r_q_peak;
                r_clip     <= r_q_clip;
                r_led      <= w_led_next;
            end
        end
    end

    assign bus.led         = r_led;
    assign bus.level       = r_level;
    assign bus.bar         = r_bar;
    assign bus.hold_idx    = r_hold_idx;
    assign bus.clip        = r_clip;
    assign bus.level_valid = r_level_valid;
endmodule
